// File: rtl/line_buffer_3x3.sv
// 3x3 sliding window over a raster pixel stream, built from two line buffers.
// Emits one window per interior pixel through a valid/ready handshake.
module line_buffer_3x3 #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_data_valid,
  output logic                    ou_data_ready,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  input  logic                    in_first_frame,
  input  logic                    in_pre_last,
  input  logic                    in_last_frame,
  output logic                    ou_result_valid,
  input  logic                    in_result_ready,
  output logic [9*DATA_WIDTH-1:0] ou_window,
  output logic                    ou_first_window,
  output logic                    ou_last_window
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  typedef logic [ColW-1:0] col_t;
  localparam col_t LastCol = col_t'(IMG_WIDTH - 1);

  if (IMG_WIDTH < 3) begin : g_bad_width
    $error("line_buffer_3x3: IMG_WIDTH must be at least 3");
  end

  logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_win [9];
  col_t                  r_col;
  logic [1:0]            r_row;
  logic                  r_valid;
  logic                  r_first;
  logic                  r_last;
  logic                  r_fresh;

  logic                  w_acc;
  logic                  w_emit;
  col_t                  w_eff_col;
  logic [1:0]            w_eff_row;
  col_t                  w_col_next;
  logic [1:0]            w_row_next;
  logic [DATA_WIDTH-1:0] w_lb0_rd;
  logic [DATA_WIDTH-1:0] w_lb1_rd;
  logic [DATA_WIDTH-1:0] w_new_col [3];
  logic                  w_unused;

  assign w_unused      = in_pre_last;
  assign ou_data_ready = ~r_valid | in_result_ready;
  assign w_acc         = in_data_valid & ou_data_ready;

  // A first-of-frame pixel restarts the raster position regardless of the counters.
  assign w_eff_col = in_first_frame ? '0 : r_col;
  assign w_eff_row = in_first_frame ? 2'd0 : r_row;
  assign w_emit    = (w_eff_row == 2'd2) && (w_eff_col >= col_t'(2));

  assign w_lb0_rd     = r_lb0[w_eff_col];
  assign w_lb1_rd     = r_lb1[w_eff_col];
  assign w_new_col[0] = w_lb1_rd;
  assign w_new_col[1] = w_lb0_rd;
  assign w_new_col[2] = in_pixel;

  always_comb begin
    w_col_next = r_col;
    w_row_next = r_row;
    if (w_acc) begin
      if (in_last_frame) begin
        w_col_next = '0;
        w_row_next = 2'd0;
      end else if (w_eff_col == LastCol) begin
        w_col_next = '0;
        w_row_next = (w_eff_row == 2'd2) ? 2'd2 : w_eff_row + 2'd1;
      end else begin
        w_col_next = w_eff_col + col_t'(1);
        w_row_next = w_eff_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= 2'd0;
    end else begin
      r_col <= w_col_next;
      r_row <= w_row_next;
    end
  end

  // Line buffer contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb1[w_eff_col] <= w_lb0_rd;
      r_lb0[w_eff_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
    end else if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[3*r]   <= r_win[3*r+1];
        r_win[3*r+1] <= r_win[3*r+2];
        r_win[3*r+2] <= w_new_col[r];
      end
    end
  end

  // r_fresh marks that no window has been emitted yet since the last frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_fresh <= 1'b1;
    end else if (w_acc) begin
      r_valid <= w_emit;
      r_first <= w_emit & r_fresh;
      r_last  <= w_emit & in_last_frame;
      if (in_first_frame | in_last_frame) begin
        r_fresh <= 1'b1;
      end else if (w_emit) begin
        r_fresh <= 1'b0;
      end
    end else if (in_result_ready) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  always_comb begin
    ou_window = '0;
    for (int k = 0; k < 9; k++) begin
      ou_window[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
    end
  end

  assign ou_result_valid = r_valid;
  assign ou_first_window = r_first;
  assign ou_last_window  = r_last;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Randomised and directed checks of line_buffer_3x3 against a frame-position
// reference model; a second IMG_WIDTH=3 instance covers the minimum width.
module tb_line_buffer_3x3;

  localparam int W  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_data_valid = 1'b0;
  logic          ou_data_ready;
  logic [DW-1:0] in_pixel = '0;
  logic          in_first_frame = 1'b0;
  logic          in_pre_last = 1'b0;
  logic          in_last_frame = 1'b0;
  logic          ou_result_valid;
  logic          in_result_ready = 1'b1;
  logic [9*DW-1:0] ou_window;
  logic          ou_first_window;
  logic          ou_last_window;

  logic          d3_data_valid = 1'b0;
  logic          d3_data_ready;
  logic [DW-1:0] d3_pixel = '0;
  logic          d3_first = 1'b0;
  logic          d3_pre_last = 1'b0;
  logic          d3_last = 1'b0;
  logic          d3_result_valid;
  logic          d3_result_ready = 1'b1;
  logic [9*DW-1:0] d3_window;
  logic          d3_first_window;
  logic          d3_last_window;

  line_buffer_3x3 #(.IMG_WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_data_valid(in_data_valid), .ou_data_ready(ou_data_ready),
    .in_pixel(in_pixel), .in_first_frame(in_first_frame), .in_pre_last(in_pre_last),
    .in_last_frame(in_last_frame), .ou_result_valid(ou_result_valid),
    .in_result_ready(in_result_ready), .ou_window(ou_window),
    .ou_first_window(ou_first_window), .ou_last_window(ou_last_window)
  );

  line_buffer_3x3 #(.IMG_WIDTH(3), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst(rst), .in_data_valid(d3_data_valid), .ou_data_ready(d3_data_ready),
    .in_pixel(d3_pixel), .in_first_frame(d3_first), .in_pre_last(d3_pre_last),
    .in_last_frame(d3_last), .ou_result_valid(d3_result_valid),
    .in_result_ready(d3_result_ready), .ou_window(d3_window),
    .ou_first_window(d3_first_window), .ou_last_window(d3_last_window)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Small non-negative integer to IEEE-754 single.
  function automatic logic [31:0] fp(input int k);
    int e;
    logic [31:0] m;
    if (k <= 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (k[b]) e = b;
    m = 32'(k) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Window whose three rows start at a, b, c (each row three consecutive values).
  function automatic logic [9*DW-1:0] win3(input int a, input int b, input int c);
    logic [9*DW-1:0] w;
    for (int j = 0; j < 3; j++) begin
      w[j*DW +: DW]     = fp(a + j);
      w[(3+j)*DW +: DW] = fp(b + j);
      w[(6+j)*DW +: DW] = fp(c + j);
    end
    return w;
  endfunction

  // Reference model: pixels of the current frame segment, indexed by raster position.
  logic            m_valid = 1'b0;
  logic            m_first = 1'b0;
  logic            m_last = 1'b0;
  logic [9*DW-1:0] m_win = '0;
  int              seg_n = 0;
  logic [DW-1:0]   seg_px [0:255];

  always @(posedge clk) begin : model
    int r, c, idx;
    if (rst) begin
      m_valid = 1'b0;
      m_first = 1'b0;
      m_last  = 1'b0;
      seg_n   = 0;
    end else if (in_data_valid && (!m_valid || in_result_ready)) begin
      if (in_first_frame) seg_n = 0;
      if (seg_n < 256) seg_px[seg_n] = in_pixel;
      r = seg_n / W;
      c = seg_n % W;
      if (r >= 2 && c >= 2) begin
        m_valid = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            idx = (r - 2 + i) * W + (c - 2 + j);
            m_win[(3*i+j)*DW +: DW] = seg_px[idx];
          end
        m_first = (seg_n == 2 * W + 2);
        m_last  = in_last_frame;
      end else begin
        m_valid = 1'b0;
      end
      seg_n = in_last_frame ? 0 : seg_n + 1;
    end else if (in_result_ready) begin
      m_valid = 1'b0;
    end
  end

  logic            chk_en = 1'b0;
  logic [9*DW-1:0] got_win [$];
  logic            got_first [$];
  logic            got_last [$];
  logic [9*DW-1:0] s1_win [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_ready", ou_data_ready, !m_valid || in_result_ready);
      check("result_valid", ou_result_valid, m_valid);
      if (m_valid) begin
        check("window", ou_window, m_win);
        check("first_window", ou_first_window, m_first);
        check("last_window", ou_last_window, m_last);
      end
      if (ou_result_valid && in_result_ready) begin
        got_win.push_back(ou_window);
        got_first.push_back(ou_first_window);
        got_last.push_back(ou_last_window);
      end
    end
  end

  int d3_mon = 0;
  int d3_cnt = 0;
  logic [9*DW-1:0] d3_got_win = '0;
  logic d3_got_first = 1'b0;
  logic d3_got_last = 1'b0;
  always @(negedge clk) begin
    if (d3_mon != 0 && d3_result_valid) begin
      d3_cnt++;
      d3_got_win   = d3_window;
      d3_got_first = d3_first_window;
      d3_got_last  = d3_last_window;
    end
  end

  int rdy_mode = 0;
  int rdy_ph = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: in_result_ready = 1'b1;
      1: begin
        in_result_ready = (rdy_ph == 0 || rdy_ph == 3);
        rdy_ph = (rdy_ph + 1) % 4;
      end
      default: in_result_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] p, input logic f, input logic pl, input logic l);
    bit done = 0;
    in_data_valid  = 1'b1;
    in_pixel       = p;
    in_first_frame = f;
    in_pre_last    = pl;
    in_last_frame  = l;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = ou_data_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    in_data_valid  = 1'b0;
    in_first_frame = 1'b0;
    in_pre_last    = 1'b0;
    in_last_frame  = 1'b0;
  endtask

  task automatic send_frame_fp(input int base, input int h);
    for (int k = 0; k < W * h; k++)
      send(fp(base + k), k == 0, k == W * h - 2, k == W * h - 1);
  endtask

  task automatic clear_got();
    got_win.delete();
    got_first.delete();
    got_last.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int h;
    bit use_first;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", ou_result_valid, 0);
    check("rst_window", ou_window, 0);
    check("rst_first", ou_first_window, 0);
    check("rst_last", ou_last_window, 0);
    check("rst_ready", ou_data_ready, 1);
    check("rst_d3_valid", d3_result_valid, 0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 frame, always ready
    clear_got();
    send_frame_fp(0, 4);
    idle(4);
    check("s1_count", got_win.size(), 4);
    if (got_win.size() >= 4) begin
      check("s1_first_win", got_win[0], win3(0, 4, 8));
      check("s1_first_flag", got_first[0], 1);
      check("s1_last_win", got_win[3], win3(5, 9, 13));
      check("s1_last_flag", got_last[3], 1);
    end
    s1_win = got_win;

    // Same frame under 1-0-0-1 backpressure
    clear_got();
    rdy_mode = 1;
    send_frame_fp(0, 4);
    rdy_mode = 0;
    idle(4);
    check("s2_count", got_win.size(), 4);
    for (int i = 0; i < got_win.size() && i < s1_win.size(); i++)
      check("s2_seq", got_win[i], s1_win[i]);

    // Two back-to-back frames
    clear_got();
    send_frame_fp(0, 4);
    send_frame_fp(16, 4);
    idle(4);
    check("s3_count", got_win.size(), 8);
    if (got_win.size() >= 8) begin
      check("s3_f1_last", got_win[3], win3(5, 9, 13));
      check("s3_f2_first", got_win[4], win3(16, 20, 24));
      check("s3_f2_first_flag", got_first[4], 1);
      check("s3_f2_last", got_win[7], win3(21, 25, 29));
    end

    // Mid-frame restart at pixel 6
    clear_got();
    for (int k = 0; k < 6; k++) send(fp(200 + k), k == 0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) send(fp(50 + k), k == 0, k == 14, k == 15);
    idle(4);
    check("s4_count", got_win.size(), 4);
    if (got_win.size() >= 1) begin
      check("s4_first_win", got_win[0], win3(50, 54, 58));
      check("s4_first_flag", got_first[0], 1);
    end

    // Reset after pixel 9, then resend the full frame
    for (int k = 0; k < 10; k++) send(fp(k), k == 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("s5_rst_valid", ou_result_valid, 0);
    @(posedge clk);
    #1;
    clear_got();
    send_frame_fp(0, 4);
    idle(4);
    check("s5_count", got_win.size(), 4);
    for (int i = 0; i < got_win.size() && i < s1_win.size(); i++)
      check("s5_seq", got_win[i], s1_win[i]);

    // Random frames, random backpressure and gaps
    clear_got();
    exp_cnt = 0;
    rdy_mode = 2;
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 4) == 0) send($urandom, 1'b1, 1'b0, 1'b1);
      h = $urandom_range(3, 6);
      use_first = 1'($urandom_range(0, 1));
      for (int k = 0; k < W * h; k++) begin
        send($urandom, use_first && k == 0, k == W * h - 2, k == W * h - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      exp_cnt += (W - 2) * (h - 2);
    end
    rdy_mode = 0;
    idle(6);
    check("rand_count", got_win.size(), exp_cnt);

    // IMG_WIDTH=3, single 3x3 frame
    d3_mon = 1;
    for (int k = 0; k < 9; k++) begin
      d3_data_valid = 1'b1;
      d3_pixel      = fp(k);
      d3_first      = (k == 0);
      d3_pre_last   = (k == 7);
      d3_last       = (k == 8);
      @(posedge clk);
      #1;
    end
    d3_data_valid = 1'b0;
    d3_first      = 1'b0;
    d3_pre_last   = 1'b0;
    d3_last       = 1'b0;
    idle(3);
    d3_mon = 0;
    check("w3_count", d3_cnt, 1);
    check("w3_window", d3_got_win, win3(0, 3, 6));
    check("w3_first_flag", d3_got_first, 1);
    check("w3_last_flag", d3_got_last, 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
